eight_bit_wallace_tree_final_accum: RTL and testbench

Final stage after the last Wallace-tree reduction layer of the 8x8 multiplier datapath. It takes the two remaining 16-bit partial rows (sum row, carry row) and registers them. It then resolves them with a carry-propagate adder and accumulates a programmed-length run of products into a wide accumulator. The result is presented to the consumer over a valid/ready handshake.

---
 rtl/eight_bit_wallace_tree_final_accum_pkg.sv | 14 +
 rtl/one_bit_full_adder.sv | 13 +
 rtl/wallace_cpa_16.sv | 28 ++
 rtl/eight_bit_wallace_tree_final_accum.sv | 151 +++++++++++++++
 tb/tb_eight_bit_wallace_tree_final_accum.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/eight_bit_wallace_tree_final_accum_pkg.sv
// rtl/eight_bit_wallace_tree_final_accum_pkg.sv - shared constants and FSM encoding for the final-accumulate stage
package eight_bit_wallace_tree_final_accum_pkg;

    localparam int ROW_W         = 16;
    localparam int DEFAULT_ACC_W = 20;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/one_bit_full_adder.sv
// rtl/one_bit_full_adder.sv - single-bit full adder cell
module one_bit_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/wallace_cpa_16.sv
// rtl/wallace_cpa_16.sv - 16-bit ripple carry-propagate adder built from full-adder cells
module wallace_cpa_16
    import eight_bit_wallace_tree_final_accum_pkg::*;
(
    input  logic [ROW_W-1:0] a_i,
    input  logic [ROW_W-1:0] b_i,
    input  logic             cin_i,
    output logic [ROW_W-1:0] sum_o,
    output logic             cout_o
);

    logic [ROW_W:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < ROW_W; i++) begin : g_fa
        one_bit_full_adder u_fa (
            .a_i   (a_i[i]),
            .b_i   (b_i[i]),
            .cin_i (carry[i]),
            .sum_o (sum_o[i]),
            .cout_o(carry[i+1])
        );
    end

    assign cout_o = carry[ROW_W];

endmodule

// File: rtl/eight_bit_wallace_tree_final_accum.sv
// rtl/eight_bit_wallace_tree_final_accum.sv - registers reduced rows, resolves them and accumulates a run of products
module eight_bit_wallace_tree_final_accum
    import eight_bit_wallace_tree_final_accum_pkg::*;
#(
    parameter int ACC_W = DEFAULT_ACC_W,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] run_len,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROW_W-1:0] row_s,
    input  logic [ROW_W-1:0] row_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf,
    output logic             prod_err,
    output logic [CNT_W-1:0] mac_count
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   taken_q, taken_d;
    logic [CNT_W-1:0]   mac_q, mac_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               perr_q, perr_d;
    logic               s1_valid_q, s1_valid_d;
    logic [ROW_W-1:0]   s1_s_q, s1_s_d;
    logic [ROW_W-1:0]   s1_c_q, s1_c_d;

    logic [ROW_W-1:0]   prod_sum;
    logic               prod_cout;
    logic [ACC_W:0]     acc_wide;
    logic [CNT_W-1:0]   mac_inc;
    logic               accept;

    wallace_cpa_16 u_cpa (
        .a_i   (s1_s_q),
        .b_i   (s1_c_q),
        .cin_i (1'b0),
        .sum_o (prod_sum),
        .cout_o(prod_cout)
    );

    // Extra top bit of acc_wide captures the wrap of the accumulator.
    assign acc_wide = {1'b0, acc_q} + {1'b0, ACC_W'(prod_sum)};
    assign mac_inc  = mac_q + CNT_W'(1);

    assign in_ready  = (state_q == ST_RUN) && (taken_q < len_q);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign acc_out   = acc_q;
    assign acc_ovf   = ovf_q;
    assign prod_err  = perr_q;
    assign mac_count = mac_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        taken_d    = taken_q;
        mac_d      = mac_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        perr_d     = perr_q;
        s1_valid_d = 1'b0;
        s1_s_d     = s1_s_q;
        s1_c_d     = s1_c_q;

        if (clear) begin
            state_d = ST_IDLE;
            len_d   = '0;
            taken_d = '0;
            mac_d   = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
            perr_d  = 1'b0;
            s1_s_d  = '0;
            s1_c_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && (run_len != '0)) begin
                        state_d = ST_RUN;
                        len_d   = run_len;
                        taken_d = '0;
                        mac_d   = '0;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        perr_d  = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        s1_valid_d = 1'b1;
                        s1_s_d     = row_s;
                        s1_c_d     = row_c;
                        taken_d    = taken_q + CNT_W'(1);
                    end
                    // DONE is entered on the same edge the final product lands.
                    if (s1_valid_q) begin
                        acc_d  = acc_wide[ACC_W-1:0];
                        ovf_d  = ovf_q | acc_wide[ACC_W];
                        perr_d = perr_q | prod_cout;
                        mac_d  = mac_inc;
                        if (mac_inc == len_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            taken_q    <= '0;
            mac_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_s_q     <= '0;
            s1_c_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            taken_q    <= taken_d;
            mac_q      <= mac_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            perr_q     <= perr_d;
            s1_valid_q <= s1_valid_d;
            s1_s_q     <= s1_s_d;
            s1_c_q     <= s1_c_d;
        end
    end

endmodule

// File: tb/tb_eight_bit_wallace_tree_final_accum.sv
// tb/tb_eight_bit_wallace_tree_final_accum.sv - scoreboard bench for the final-accumulate stage
module tb_eight_bit_wallace_tree_final_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  run_len;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] row_s;
    logic [15:0] row_c;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] acc_out;
    logic        acc_ovf;
    logic        prod_err;
    logic [7:0]  mac_count;

    typedef struct packed {
        logic [19:0] acc;
        logic        ovf;
        logic        perr;
        logic [7:0]  mac;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    eight_bit_wallace_tree_final_accum #(.ACC_W(20), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .run_len  (run_len),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .row_s    (row_s),
        .row_c    (row_c),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc_out  (acc_out),
        .acc_ovf  (acc_ovf),
        .prod_err (prod_err),
        .mac_count(mac_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Result monitor: the handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got acc 0x%0h expected no result", acc_out);
            end else begin
                e = sb.pop_front();
                check("acc_out", 32'(acc_out), 32'(e.acc));
                check("acc_ovf", 32'(acc_ovf), 32'(e.ovf));
                check("prod_err", 32'(prod_err), 32'(e.perr));
                check("mac_count", 32'(mac_count), 32'(e.mac));
            end
        end
    end

    task automatic start_run(input logic [7:0] n);
        start   = 1'b1;
        run_len = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic feed(input logic [15:0] s, input logic [15:0] c);
        int n = 0;
        row_s    = s;
        row_c    = c;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: got in_ready 0 expected 1");
        end
        tick();
    endtask

    task automatic finish_run();
        int n = 0;
        in_valid = 1'b0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got out_valid 0 expected 1");
        end
        if (out_ready) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        run_len   = '0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        row_s     = '0;
        row_c     = '0;
        out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_acc_out", 32'(acc_out), 0);
        check("rst_flags", 32'({acc_ovf, prod_err}), 0);
        check("rst_mac_count", 32'(mac_count), 0);
        rst_n = 1'b1;
        tick();

        // Idle: in_valid without start has no effect.
        in_valid = 1'b1;
        row_s    = 16'h1234;
        row_c    = 16'h0001;
        repeat (3) tick();
        in_valid = 1'b0;
        tick();
        check("idle_mac_count", 32'(mac_count), 0);
        check("idle_acc_out", 32'(acc_out), 0);
        check("idle_in_ready", 32'(in_ready), 0);

        // Basic run with explicit latency checks.
        sb.push_back('{acc: 20'h01FF3, ovf: 1'b0, perr: 1'b0, mac: 8'd3});
        start_run(8'd3);
        feed(16'h0F00, 16'h00F1);
        feed(16'h0001, 16'h0001);
        feed(16'h1000, 16'h0000);
        in_valid = 1'b0;
        check("basic_lat1_out_valid", 32'(out_valid), 0);
        check("basic_lat1_mac", 32'(mac_count), 2);
        tick();
        check("basic_lat2_out_valid", 32'(out_valid), 1);
        tick();
        check("basic_idle_out_valid", 32'(out_valid), 0);

        // Overflow: 17 x 0xFE01 wraps 20 bits.
        sb.push_back('{acc: 20'h0DE11, ovf: 1'b1, perr: 1'b0, mac: 8'd17});
        start_run(8'd17);
        for (int i = 0; i < 17; i++) feed(16'hFE01, 16'h0000);
        finish_run();

        sb.push_back('{acc: 20'hFE010, ovf: 1'b0, perr: 1'b0, mac: 8'd16});
        start_run(8'd16);
        for (int i = 0; i < 16; i++) feed(16'hFE01, 16'h0000);
        finish_run();

        // Row carry-out.
        sb.push_back('{acc: 20'h00000, ovf: 1'b0, perr: 1'b1, mac: 8'd1});
        start_run(8'd1);
        feed(16'hFFFF, 16'h0001);
        finish_run();

        // Backpressure: result held, start and in_valid ignored.
        out_ready = 1'b0;
        sb.push_back('{acc: 20'h00037, ovf: 1'b0, perr: 1'b0, mac: 8'd2});
        start_run(8'd2);
        feed(16'h0010, 16'h0020);
        feed(16'h0003, 16'h0004);
        finish_run();
        for (int i = 0; i < 10; i++) begin
            start    = (i == 4);
            run_len  = 8'd4;
            in_valid = (i >= 4);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_acc_out", 32'(acc_out), 32'h37);
            check("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("bp_mac_count", 32'(mac_count), 2);
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 32'(out_valid), 0);
        check("bp_release_in_ready", 32'(in_ready), 0);

        // Abort with clear on the third beat, then a fresh run.
        start_run(8'd5);
        feed(16'h0001, 16'h0001);
        feed(16'h0002, 16'h0002);
        clear = 1'b1;
        feed(16'h0003, 16'h0003);
        clear    = 1'b0;
        in_valid = 1'b0;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_acc_out", 32'(acc_out), 0);
        check("abort_mac_count", 32'(mac_count), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        tick();
        check("abort_hold_acc_out", 32'(acc_out), 0);

        sb.push_back('{acc: 20'h00005, ovf: 1'b0, perr: 1'b0, mac: 8'd1});
        start_run(8'd1);
        feed(16'h0002, 16'h0003);
        finish_run();

        repeat (3) tick();
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
